// File: rtl/blit_cmd_queue.sv
// ----------------------------------------------------------------------------
// blit_cmd_queue
//   Command queue feeding blit_command. The CPU assembles a 96-bit command
//   from three 32-bit register writes: ARG1 and ARG2 load staging registers,
//   and a write to CMD pushes {arg2, arg1, wdata} into a FIFO. The FIFO head
//   is presented first-word-fall-through on cmd/cmd_valid and is popped by a
//   one-cycle next_cmd pulse. A STATUS register exposes fill level, sticky
//   overflow and a combined idle indication, and supports clear/flush.
// ----------------------------------------------------------------------------
module blit_cmd_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic [95:0] cmd,
    output logic        cmd_valid,
    input  logic        next_cmd,
    input  logic        blit_idle
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    // Bit positions inside a STATUS write.
    localparam int STAT_CLR_OVF_BIT = 18;
    localparam int STAT_FLUSH_BIT   = 31;

    // CPU register map.
    typedef enum logic [1:0] {
        ADDR_ARG1   = 2'd0,
        ADDR_ARG2   = 2'd1,
        ADDR_CMD    = 2'd2,
        ADDR_STATUS = 2'd3
    } addr_e;

    // STATUS read layout, most significant field first.
    typedef struct packed {
        logic [11:0] zero;
        logic        idle;
        logic        overflow;
        logic        full;
        logic        empty;
        logic [15:0] count;
    } status_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [95:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic [31:0]           r_arg1;
    logic [31:0]           r_arg2;
    logic                  r_ack;
    logic [31:0]           r_rdata;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    addr_e   w_addr;
    logic    w_wr;
    logic    w_rd;
    logic    w_push_req;
    logic    w_stat_wr;
    logic    w_flush;
    logic    w_clr_ovf;
    logic    w_empty;
    logic    w_full;
    logic    w_pop;
    logic    w_push;
    logic    w_ovf_set;
    status_t w_status;
    logic [31:0] w_rd_data;

    assign w_addr     = addr_e'(cpu_addr);
    assign w_wr       = cpu_valid && cpu_write;
    assign w_rd       = cpu_valid && !cpu_write;
    assign w_push_req = w_wr && (w_addr == ADDR_CMD);
    assign w_stat_wr  = w_wr && (w_addr == ADDR_STATUS);
    assign w_flush    = w_stat_wr && cpu_wdata[STAT_FLUSH_BIT];
    assign w_clr_ovf  = w_stat_wr && cpu_wdata[STAT_CLR_OVF_BIT];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));

    // A flush retires everything, so a coincident pop has nothing to act on.
    assign w_pop      = next_cmd && !w_empty && !w_flush;

    // When full, a same-cycle pop frees the slot the push lands in.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;

    assign w_status.zero     = '0;
    assign w_status.idle     = w_empty && blit_idle;
    assign w_status.overflow = r_overflow;
    assign w_status.full     = w_full;
    assign w_status.empty    = w_empty;
    assign w_status.count    = 16'(r_count);

    // Select read data from the pre-access register state.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_rd_data unassigned (no latch).
        w_rd_data = '0;
        case (w_addr)
            ADDR_ARG1:   w_rd_data = r_arg1;
            ADDR_ARG2:   w_rd_data = r_arg2;
            ADDR_CMD:    w_rd_data = '0;
            ADDR_STATUS: w_rd_data = w_status;
            default:     w_rd_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Command storage
    // ------------------------------------------------------------------

    // Write the assembled command into the slot at the write pointer.
    always_ff @(posedge clock) begin
        // NOTE: the RAM has no reset; only the pointers/count decide what is valid.
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_arg2, r_arg1, cpu_wdata};
        end
    end

    // Head of queue falls through combinationally; undefined while empty.
    assign cmd       = r_mem[r_rd_ptr];
    assign cmd_valid = !w_empty;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------

    // Pointer and occupancy bookkeeping, including flush.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // Argument staging registers; values persist across pushes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_arg1 <= '0;
            r_arg2 <= '0;
        end else if (w_wr) begin
            if (w_addr == ADDR_ARG1) begin
                r_arg1 <= cpu_wdata;
            end
            if (w_addr == ADDR_ARG2) begin
                r_arg2 <= cpu_wdata;
            end
        end
    end

    // Registered bus response: ack one cycle after every request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= cpu_valid;
            r_rdata <= w_rd ? w_rd_data : '0;
        end
    end

    assign cpu_ack   = r_ack;
    assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_blit_cmd_queue.sv
// ----------------------------------------------------------------------------
// tb_blit_cmd_queue
//   Directed scenarios with literal expectations, followed by a randomized
//   phase. A queue-based reference model tracks the command FIFO, staging
//   registers, overflow flag and expected bus response; a compare process
//   checks the DUT against it on every falling edge.
// ----------------------------------------------------------------------------
module tb_blit_cmd_queue;

    localparam int DEPTH = 16;

    logic        clock;
    logic        reset;
    logic        cpu_valid;
    logic        cpu_write;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic [95:0] cmd;
    logic        cmd_valid;
    logic        next_cmd;
    logic        blit_idle;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    blit_cmd_queue #(.DEPTH_LOG2(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_valid (cpu_valid),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .next_cmd  (next_cmd),
        .blit_idle (blit_idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [95:0] q[$];
    logic [31:0] m_arg1, m_arg2, m_rdata;
    logic        m_ovf, m_ack, m_rd;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(q.size());
        s[16] = (q.size() == 0);
        s[17] = (q.size() == DEPTH);
        s[18] = m_ovf;
        s[19] = (q.size() == 0) && blit_idle;
        return s;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            m_arg1 = '0; m_arg2 = '0; m_ovf = 0;
            m_ack = 0; m_rd = 0; m_rdata = '0;
        end else begin
            m_ack   = cpu_valid;
            m_rd    = cpu_valid && !cpu_write;
            m_rdata = '0;
            if (m_rd) begin
                case (cpu_addr)
                    2'd0: m_rdata = m_arg1;
                    2'd1: m_rdata = m_arg2;
                    2'd2: m_rdata = '0;
                    default: m_rdata = model_status();
                endcase
            end
            if (cpu_valid && cpu_write && cpu_addr == 2'd3 && cpu_wdata[31])
                q.delete();
            else if (next_cmd && q.size() > 0)
                void'(q.pop_front());
            if (cpu_valid && cpu_write && cpu_addr == 2'd3 && cpu_wdata[18])
                m_ovf = 0;
            if (cpu_valid && cpu_write && cpu_addr == 2'd2) begin
                if (q.size() < DEPTH) q.push_back({m_arg2, m_arg1, cpu_wdata});
                else m_ovf = 1;
            end
            if (cpu_valid && cpu_write && cpu_addr == 2'd0) m_arg1 = cpu_wdata;
            if (cpu_valid && cpu_write && cpu_addr == 2'd1) m_arg2 = cpu_wdata;
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            check("cmd_valid", 96'(cmd_valid), 96'(q.size() != 0));
            if (q.size() != 0) check("cmd_head", cmd, q[0]);
            check("cpu_ack", 96'(cpu_ack), 96'(m_ack));
            if (m_ack && m_rd) check("cpu_rdata", 96'(cpu_rdata), 96'(m_rdata));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at the next one)
    // ------------------------------------------------------------------
    task automatic bus(input logic wr, input logic [1:0] a, input logic [31:0] d, input logic pop);
        cpu_valid = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = d; next_cmd = pop;
        @(negedge clock);
        cpu_valid = 1'b0; cpu_write = 1'b0; cpu_addr = 2'd0; cpu_wdata = '0; next_cmd = 1'b0;
    endtask

    task automatic pop_only();
        next_cmd = 1'b1;
        @(negedge clock);
        next_cmd = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus(1'b0, a, 32'h0, 1'b0);
        d = cpu_rdata;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) bus(1'b1, 2'd2, base + 32'(i), 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) pop_only();
    endtask

    logic [31:0] rd;

    initial begin
        reset = 1'b1; cpu_valid = 0; cpu_write = 0; cpu_addr = 0;
        cpu_wdata = 0; next_cmd = 0; blit_idle = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk_en = 1;

        // 1: assemble and push one command
        bus(1'b1, 2'd0, 32'h00200010, 1'b0);
        bus(1'b1, 2'd1, 32'h00400030, 1'b0);
        bus(1'b1, 2'd2, 32'h00000005, 1'b0);
        check("t1_valid", 96'(cmd_valid), 96'd1);
        check("t1_cmd", cmd, 96'h00400030_00200010_00000005);
        read_reg(2'd3, rd);
        check("t1_status", 96'(rd), 96'h00000001);
        pop_only();

        // 2: fill, overflow, drain in order
        push_n(16, 32'h100);
        read_reg(2'd3, rd);
        check("t2_full", 96'(rd), 96'h00020010);
        bus(1'b1, 2'd2, 32'hDEAD, 1'b0);
        read_reg(2'd3, rd);
        check("t2_ovf", 96'(rd), 96'h00060010);
        for (int i = 0; i < 16; i++) begin
            check("t2_order", 96'(cmd[31:0]), 96'(32'h100 + 32'(i)));
            pop_only();
        end
        check("t2_empty", 96'(cmd_valid), 96'd0);

        // 3: push+pop on full, pointer wrap
        bus(1'b1, 2'd3, 32'h00040000, 1'b0);
        push_n(16, 32'h300);
        bus(1'b1, 2'd2, 32'h200, 1'b1);
        read_reg(2'd3, rd);
        check("t3_full", 96'(rd), 96'h00020010);
        for (int i = 1; i < 16; i++) begin
            check("t3_order", 96'(cmd[31:0]), 96'(32'h300 + 32'(i)));
            pop_only();
        end
        check("t3_last", 96'(cmd[31:0]), 96'h200);
        pop_only();

        // 4: pop on empty, push+pop on empty
        pop_only();
        read_reg(2'd3, rd);
        check("t4_empty", 96'(rd), 96'h00010000);
        bus(1'b1, 2'd2, 32'h400, 1'b1);
        read_reg(2'd3, rd);
        check("t4_one", 96'(rd), 96'h00000001);
        pop_only();

        // 5: flush with overflow clear, idle reporting
        push_n(17, 32'h500);
        pop_n(11);
        read_reg(2'd3, rd);
        check("t5_pre", 96'(rd), 96'h00040005);
        bus(1'b1, 2'd3, 32'h80040000, 1'b0);
        check("t5_valid", 96'(cmd_valid), 96'd0);
        blit_idle = 1'b1;
        read_reg(2'd3, rd);
        check("t5_idle1", 96'(rd), 96'h00090000);
        blit_idle = 1'b0;
        read_reg(2'd3, rd);
        check("t5_idle0", 96'(rd), 96'h00010000);

        // 6: reset mid-operation
        push_n(17, 32'h600);
        pop_n(13);
        read_reg(2'd3, rd);
        check("t6_pre", 96'(rd), 96'h00040003);
        blit_idle = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_valid", 96'(cmd_valid), 96'd0);
        check("t6_ack", 96'(cpu_ack), 96'd0);
        read_reg(2'd3, rd);
        check("t6_status", 96'(rd), 96'h00090000);
        read_reg(2'd0, rd);
        check("t6_arg1", 96'(rd), 96'd0);

        // Randomized phase, checked by the model
        for (int c = 0; c < 4000; c++) begin
            cpu_valid = ($urandom_range(0, 9) < 6);
            cpu_write = ($urandom_range(0, 3) != 0);
            cpu_addr  = 2'($urandom_range(0, 5) > 3 ? $urandom_range(0, 3) : 2);
            cpu_wdata = $urandom;
            if ($urandom_range(0, 15) != 0) cpu_wdata[31] = 1'b0;
            next_cmd  = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 31) == 0) blit_idle = ~blit_idle;
            @(negedge clock);
        end
        cpu_valid = 0; next_cmd = 0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
